// File: rtl/spi_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_scheduler
// Purpose  : Walks a decimated frame in raster order, fetches pixels from BRAM
//            and hands each one to an SPI sender, pacing on its chip-select.
//            Optional FRAME_CHECKSUM_EN appends a checksum transaction.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_scheduler #(
    parameter int H_COUNT        = 640,
    parameter int V_COUNT        = 360,
    parameter int H_STEP         = 4,
    parameter int V_STEP         = 4,
    parameter int ADDR_WIDTH     = 14,
    parameter int BRAM_LATENCY   = 2,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic [7:0]            rd_data_in,
    input  logic                  cs_in,
    output logic                  rd_en_out,
    output logic [ADDR_WIDTH-1:0] rd_addr_out,
    output logic                  trigger_out,
    output logic [7:0]            data_out,
    output logic [9:0]            hcount_out,
    output logic [8:0]            vcount_out,
    output logic                  busy_out,
    output logic                  frame_done_out,
    output logic                  error_out
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [9:0]       c_H_LAST  = 10'(H_COUNT - H_STEP);
    localparam logic [9:0]       c_H_STEP  = 10'(H_STEP);
    localparam logic [8:0]       c_V_LAST  = 9'(V_COUNT - V_STEP);
    localparam logic [8:0]       c_V_STEP  = 9'(V_STEP);
    localparam logic [CNT_W-1:0] c_LAT_END = CNT_W'(BRAM_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_GAP_END = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TMO_END = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_LAT       = 4'd2,
        S_SEND      = 4'd3,
        S_WAIT_BUSY = 4'd4,
        S_WAIT_IDLE = 4'd5,
        S_GAP       = 4'd6,
        S_DONE      = 4'd7
`ifdef FRAME_CHECKSUM_EN
        , S_CKSUM   = 4'd8
`endif
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [9:0]            r_h;
    logic [8:0]            r_v;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_data;
    logic [9:0]            r_hout;
    logic [8:0]            r_vout;
    logic                  r_err;
    logic                  r_abort;
    logic                  w_last;
    logic                  w_abort;
    logic                  w_tmo;
    logic                  w_gap_end;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]            r_sum;
    logic                  r_ck_phase;
`endif

    assign w_last    = (r_h == c_H_LAST) && (r_v == c_V_LAST);
    assign w_abort   = r_abort | abort_in;
    assign w_gap_end = (r_state == S_GAP) && (r_cnt == c_GAP_END);
    assign w_tmo     = (r_cnt == c_TMO_END) &&
                       (((r_state == S_WAIT_BUSY) &&  cs_in) ||
                        ((r_state == S_WAIT_IDLE) && !cs_in));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start_in) w_next = S_FETCH;
            S_FETCH:     w_next = S_LAT;
            S_LAT:       if (r_cnt == c_LAT_END) w_next = S_SEND;
            S_SEND:      w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!cs_in) w_next = S_WAIT_IDLE;
                         else if (w_tmo) w_next = S_IDLE;
            S_WAIT_IDLE: if (cs_in) w_next = S_GAP;
                         else if (w_tmo) w_next = S_IDLE;
            S_GAP: begin
                if (w_gap_end) begin
`ifdef FRAME_CHECKSUM_EN
                    // The checksum pass re-enters GAP with w_last still true.
                    if (r_ck_phase || w_abort) w_next = S_DONE;
                    else if (w_last)           w_next = S_CKSUM;
                    else                       w_next = S_FETCH;
`else
                    if (w_abort || w_last) w_next = S_DONE;
                    else                   w_next = S_FETCH;
`endif
                end
            end
`ifdef FRAME_CHECKSUM_EN
            S_CKSUM:     w_next = S_WAIT_BUSY;
`endif
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_h        <= '0;
            r_v        <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_hout     <= '0;
            r_vout     <= '0;
            r_err      <= 1'b0;
            r_abort    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            r_sum      <= '0;
            r_ck_phase <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            // One shared counter times latency, timeout and gap per state.
            if ((r_state == S_IDLE) || (w_next != r_state)) r_cnt <= '0;
            else                                             r_cnt <= r_cnt + CNT_W'(1);

            if ((r_state == S_IDLE) && start_in) begin
                r_err      <= 1'b0;
                r_h        <= '0;
                r_v        <= '0;
                r_addr     <= '0;
                r_abort    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
                r_sum      <= '0;
                r_ck_phase <= 1'b0;
`endif
            end else if ((r_state != S_IDLE) && abort_in) begin
                r_abort <= 1'b1;
            end

            if (w_tmo) r_err <= 1'b1;

            if ((r_state == S_LAT) && (r_cnt == c_LAT_END)) begin
                r_data <= rd_data_in;
                r_hout <= r_h;
                r_vout <= r_v;
            end

            if (w_gap_end && (w_next == S_FETCH)) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
                if (r_h == c_H_LAST) begin
                    r_h <= '0;
                    r_v <= r_v + c_V_STEP;
                end else begin
                    r_h <= r_h + c_H_STEP;
                end
            end
`ifdef FRAME_CHECKSUM_EN
            if (r_state == S_SEND) r_sum <= r_sum + r_data;
            if (w_gap_end && (w_next == S_CKSUM)) begin
                r_data     <= r_sum;
                r_hout     <= 10'h3FF;
                r_vout     <= 9'h1FF;
                r_ck_phase <= 1'b1;
            end
`endif
        end
    end

    assign rd_en_out      = (r_state == S_FETCH);
    assign rd_addr_out    = r_addr;
`ifdef FRAME_CHECKSUM_EN
    assign trigger_out    = (r_state == S_SEND) || (r_state == S_CKSUM);
`else
    assign trigger_out    = (r_state == S_SEND);
`endif
    assign data_out       = r_data;
    assign hcount_out     = r_hout;
    assign vcount_out     = r_vout;
    assign busy_out       = (r_state != S_IDLE);
    assign frame_done_out = (r_state == S_DONE);
    assign error_out      = r_err;

endmodule
`default_nettype wire

// File: doc/spi_frame_scheduler.md
Name: spi_frame_scheduler

Overview:
- Sequences one SPI pixel sender across a downsampled frame.
- Walks the frame in raster order, fetches each 8-bit pixel from a synchronous BRAM, and pulses the sender's trigger with data and coordinates.
- Waits for the sender's chip-select to assert and then release before moving to the next pixel.
- Sits between the depth frame buffer and the SPI send block.

Parameters:
- H_COUNT, 640, horizontal extent in source pixels
- V_COUNT, 360, vertical extent in source lines
- H_STEP, 4, horizontal decimation step
- V_STEP, 4, vertical decimation step
- ADDR_WIDTH, 14, BRAM address width (160*90=14400 entries)
- BRAM_LATENCY, 2, cycles from rd_en_out to valid rd_data_in
- GAP_CYCLES, 4, idle cycles between transactions after CS release
- TIMEOUT_CYCLES, 4096, maximum wait for the CS edge in either wait state

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_n_in  input  1  asynchronous active-low reset
- start_in  input  1  one-cycle pulse; begins a frame when idle
- abort_in  input  1  stop the frame after the current transaction
- rd_data_in  input  8  BRAM read data
- cs_in  input  1  sender chip_sel (low = transaction in flight)
- rd_en_out  output  1  BRAM read strobe
- rd_addr_out  output  ADDR_WIDTH  BRAM linear address
- trigger_out  output  1  one-cycle sender trigger
- data_out  output  8  pixel to send; valid while trigger_out=1
- hcount_out  output  10  source h coordinate of the current pixel
- vcount_out  output  9  source v coordinate of the current pixel
- busy_out  output  1  high from accepted start until DONE exits
- frame_done_out  output  1  one-cycle pulse at frame end
- error_out  output  1  sticky timeout flag; cleared by accepted start

Behaviour:
- Clock and reset: single clock clk_in. Reset rst_n_in is asynchronous, active-low.
- Reset values: all outputs 0. State IDLE. Counters and address 0.
- IDLE: start_in=1 goes to FETCH. This clears error_out and zeroes addr, hcount and vcount. start_in while busy is ignored.
- FETCH: rd_en_out=1 for exactly one cycle at rd_addr_out. Then wait BRAM_LATENCY cycles, latch rd_data_in into data_out, and go to SEND.
- SEND: trigger_out=1 for one cycle, with data_out, hcount_out and vcount_out stable. Go to WAIT_BUSY. data and coordinates stay held until the next SEND.
- WAIT_BUSY: wait for cs_in=0, then go to WAIT_IDLE. If cs_in is already 0 on the first cycle, that counts.
- WAIT_IDLE: wait for cs_in=1, then go to GAP.
- Timeout: a counter resets on entry to WAIT_BUSY and to WAIT_IDLE. If it reaches TIMEOUT_CYCLES, set error_out=1 and go to IDLE with busy_out=0. No frame_done_out is issued.
- GAP: hold for GAP_CYCLES cycles, then advance:
  - hcount += H_STEP and addr += 1.
  - If hcount was H_COUNT-H_STEP, hcount wraps to 0 and vcount += V_STEP.
  - If this was the last pixel (hcount=H_COUNT-H_STEP and vcount=V_COUNT-V_STEP, i.e. 636/356), go to DONE. Otherwise go to FETCH.
- abort_in: sampled every cycle into a pending flag. It is honoured only at the GAP exit (go to DONE), so a transaction is never cut mid-flight. If the pending abort coincides with the last pixel, DONE is reached once.
- DONE: frame_done_out=1 for one cycle, then IDLE. busy_out falls in the same cycle IDLE is entered.
- Address: addr=(v/V_STEP)*(H_COUNT/H_STEP)+h/H_STEP, maintained incrementally. No wrap beyond 14399.
- Reset mid-operation: immediate return to reset values. A sender transaction in flight is not tracked.

Optional Feature:
- Macro: FRAME_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) accumulates every sent pixel, cleared at start.
  - After the last pixel's GAP, the CKSUM state sends one extra transaction: trigger with data_out=sum, hcount_out=1023, vcount_out=511.
  - CKSUM uses the same WAIT_BUSY, WAIT_IDLE and GAP sequence and timeout, then goes to DONE.
  - An aborted frame sends no checksum.
- Undefined: no CKSUM state, and the sum logic is absent.

Test Plan:
- Reset, then start with a BRAM model at addr=k → data=k[7:0] and a sender model (CS low 2 cycles after trigger, high 200 cycles later) → 14400 triggers; first at h=0/v=0 with data 0x00; last at h=636/v=356 with data 0x3F (14399 mod 256); one frame_done_out; error_out=0.
- Spacing: measure from each CS rise to the next trigger → exactly GAP_CYCLES+1+BRAM_LATENCY+1 cycles.
- Row wrap: trigger 160 → h=0, v=4, addr=160.
- cs_in stuck high after the first trigger → error_out=1 at 4096 cycles, busy_out=0, no frame_done_out; a new start clears error_out.
- abort_in pulsed during pixel 10's WAIT_IDLE → pixel 10 completes, frame_done_out fires, no 11th trigger.
- FRAME_CHECKSUM_EN defined, data=k[7:0] → extra trigger with data_out=sum mod 256 and h=1023/v=511 before frame_done_out.
- Reset asserted mid-WAIT_IDLE → all outputs 0 immediately; a later start restarts at addr 0.
